clock_edit_ctrl: RTL

//   Front-end controller for the time/date keeper. Debounces the mode and edit buttons.

---
 rtl/clock_pkg.sv | 65 ++++++
 rtl/clock_edit_ctrl_btn_debounce.sv | 59 +++++
 rtl/clock_edit_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared codes for the time/date keeper edit front-end: field ids, FSM states, blink groups.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package clock_pkg;

  typedef enum logic [2:0] {
    FLD_SEC  = 3'd0,
    FLD_MIN  = 3'd1,
    FLD_HR   = 3'd2,
    FLD_DAY  = 3'd3,
    FLD_MON  = 3'd4,
    FLD_YEAR = 3'd5
  } field_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BLINK_OFF = 2'b00,
    BLINK_LO  = 2'b01,
    BLINK_MID = 2'b10,
    BLINK_HI  = 2'b11
  } blink_t;

  // Display mux select: blink group plus page (0 = time, 1 = date)
  typedef struct packed {
    blink_t blink;
    logic   display;
  } disp_t;

  // Button slots in the debouncer bank
  localparam int BTN_MODE = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_CLR  = 3;
  localparam int BTN_EXIT = 4;
  localparam int NUM_BTN  = 5;

  // Time fields blink on the time page, date fields on the date page; RUN blanks nothing
  function automatic disp_t disp_sel(input state_t st, input field_t fld);
    disp_t d;
    d.blink   = BLINK_OFF;
    d.display = 1'b0;
    if (st == ST_EDIT) begin
      case (fld)
        FLD_SEC:  d.blink = BLINK_LO;
        FLD_MIN:  d.blink = BLINK_MID;
        FLD_HR:   d.blink = BLINK_HI;
        FLD_DAY:  begin d.blink = BLINK_LO;  d.display = 1'b1; end
        FLD_MON:  begin d.blink = BLINK_MID; d.display = 1'b1; end
        FLD_YEAR: begin d.blink = BLINK_HI;  d.display = 1'b1; end
        default:  d.blink = BLINK_OFF;
      endcase
    end
    return d;
  endfunction

  // Field advance with wrap from YEAR back to SEC
  function automatic field_t field_next(input field_t f);
    return (f == FLD_YEAR) ? FLD_SEC : field_t'(f + 3'd1);
  endfunction

endpackage

// File: rtl/clock_edit_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, debounced level and rise event.
// Latency: rise event is high 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw edge, for 1 cycle.
// Backpressure: none; events are single-cycle and not held for a consumer.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 655
) (
  input  logic clk_32_768K,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_lvl,
  output logic btn_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk_32_768K or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Flip the level only after DEBOUNCE_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk_32_768K or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      btn_lvl <= 1'b0;
    end else if (sync2 == btn_lvl) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      btn_lvl <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Registered rising-edge detect on the debounced level
  always_ff @(posedge clk_32_768K or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d    <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      lvl_d    <= btn_lvl;
      btn_rise <= btn_lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/clock_edit_ctrl.sv
// RUN/EDIT front-end for the time/date keeper: debounced buttons -> field select, inc/clr/dec pulses, blink/page select.
// Latency: command pulse one cycle after a debounced press event (raw edge + DEBOUNCE_CYCLES + 4); blink/page aligned with state.
// Backpressure: none; pulses are fire-and-forget, simultaneous lower-priority presses are dropped. Optional macro CLOCK_EDIT_AUTOREPEAT_EN.
module clock_edit_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 655,
  parameter int TIMEOUT_CYCLES  = 983040,
  parameter int REPEAT_DELAY    = 16384,
  parameter int REPEAT_PERIOD   = 3277
) (
  input  logic       clk_32_768K,
  input  logic       rst_n,
  input  logic       mode_btn_i,
  input  logic       next_btn_i,
  input  logic       inc_btn_i,
  input  logic       clr_btn_i,
  input  logic       exit_btn_i,
  output logic       edit_o,
  output logic [2:0] field_o,
  output logic       inc_o,
  output logic       clr_o,
  output logic       dec_o,
  output logic [1:0] blink_o,
  output logic       display_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] ev;

  state_t        state, state_nxt;
  field_t        field, field_nxt;
  logic          inc_nxt, clr_nxt, dec_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  disp_t         disp_q, disp_nxt;

  assign raw[BTN_MODE] = mode_btn_i;
  assign raw[BTN_NEXT] = next_btn_i;
  assign raw[BTN_INC]  = inc_btn_i;
  assign raw[BTN_CLR]  = clr_btn_i;
  assign raw[BTN_EXIT] = exit_btn_i;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_32_768K(clk_32_768K),
      .rst_n      (rst_n),
      .btn_raw    (raw[g]),
      .btn_lvl    (lvl[g]),
      .btn_rise   (ev[g])
    );
  end

`ifdef CLOCK_EDIT_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rpt_cnt, rpt_nxt;
  logic          rpt_hold;

  // Only inc, or clr on YEAR (which decrements), is worth repeating
  assign rpt_hold = lvl[BTN_INC] | (lvl[BTN_CLR] & (field == FLD_YEAR));

  logic unused_lvl;
  assign unused_lvl = ^{lvl[BTN_MODE], lvl[BTN_NEXT], lvl[BTN_EXIT]};
`else
  logic unused_cfg;
  assign unused_cfg = ^{lvl, (REPEAT_DELAY > REPEAT_PERIOD)};
`endif

  // Next state, field, command pulses and timeout; one event per cycle by priority
  always_comb begin
    state_nxt = state;
    field_nxt = field;
    inc_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    tmo_nxt   = '0;
`ifdef CLOCK_EDIT_AUTOREPEAT_EN
    rpt_nxt   = '0;
`endif
    case (state)
      ST_RUN: begin
        if (!ev[BTN_EXIT] && ev[BTN_MODE]) begin
          state_nxt = ST_EDIT;
          field_nxt = FLD_SEC;
        end
      end
      ST_EDIT: begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_RUN;
          field_nxt = FLD_SEC;
          tmo_nxt   = '0;
        end else if (ev[BTN_EXIT] || ev[BTN_MODE]) begin
          state_nxt = ST_RUN;
          field_nxt = FLD_SEC;
          tmo_nxt   = '0;
        end else if (ev[BTN_NEXT]) begin
          field_nxt = field_next(field);
          tmo_nxt   = '0;
        end else if (ev[BTN_CLR]) begin
          if (field == FLD_YEAR) dec_nxt = 1'b1;
          else                   clr_nxt = 1'b1;
          tmo_nxt = '0;
        end else if (ev[BTN_INC]) begin
          inc_nxt = 1'b1;
          tmo_nxt = '0;
        end
`ifdef CLOCK_EDIT_AUTOREPEAT_EN
        else if (rpt_hold) begin
          if (rpt_cnt == RPT_LAST) begin
            rpt_nxt = RPT_RELOAD;
            tmo_nxt = '0;
            if (lvl[BTN_CLR] && field == FLD_YEAR) dec_nxt = 1'b1;
            else                                   inc_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt_cnt + RW'(1);
          end
        end
`endif
      end
      default: state_nxt = ST_RUN;
    endcase
    disp_nxt = disp_sel(state_nxt, field_nxt);
  end

  // Control state and registered outputs; reset cuts any pulse in flight
  always_ff @(posedge clk_32_768K or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      field   <= FLD_SEC;
      inc_o   <= 1'b0;
      clr_o   <= 1'b0;
      dec_o   <= 1'b0;
      tmo_cnt <= '0;
      disp_q  <= '0;
    end else begin
      state   <= state_nxt;
      field   <= field_nxt;
      inc_o   <= inc_nxt;
      clr_o   <= clr_nxt;
      dec_o   <= dec_nxt;
      tmo_cnt <= tmo_nxt;
      disp_q  <= disp_nxt;
    end
  end

`ifdef CLOCK_EDIT_AUTOREPEAT_EN
  // Hold-time counter for auto-repeat; restarts on any press or release
  always_ff @(posedge clk_32_768K or negedge rst_n) begin
    if (!rst_n) rpt_cnt <= '0;
    else        rpt_cnt <= rpt_nxt;
  end
`endif

  assign edit_o    = (state == ST_EDIT);
  assign field_o   = field;
  assign blink_o   = disp_q.blink;
  assign display_o = disp_q.display;

endmodule
